// File: rtl/reg_bank_p_pkg.sv
// Shared types and default sizing for the reg_bank_p register bank.
// Clear-sequencer state encoding lives here so the top and sequencer agree.
package reg_bank_p_pkg;

  localparam int DW_DEFAULT    = 32;
  localparam int DEPTH_DEFAULT = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/reg_bank_p_clr_seq.sv
// Bank clear sequencer: walks idx 0..DEPTH-1, one entry per cycle, while busy.
// Requests arriving mid-sweep are dropped; reset aborts the sweep outright.
module reg_bank_p_clr_seq
  import reg_bank_p_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_t    state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    clr_en     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // busy is a pure decode of the state flop, so it is glitch-free and registered.
  assign busy    = (state_reg == CLEAR);
  assign clr_idx = idx_reg;

endmodule

// File: rtl/reg_bank_p.sv
// Register bank: 1 write port, 2 registered read ports, entry 0 hard-wired to zero.
// Define REG_BANK_P_BYPASS_EN to forward same-edge write data to the read ports.
module reg_bank_p
  import reg_bank_p_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] din,
  input  logic          re1,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] dr1,
  input  logic          re2,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] dr2,
  input  logic          clr_req,
  output logic          busy
);

  // One extra bit so DEPTH=2**AW is still representable for range checks.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_reg [DEPTH];
  logic          clr_en;
  logic [AW-1:0] clr_idx;
  logic          we_ok;

  reg_bank_p_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  assign we_ok = we && !busy && (wa != '0) && ({1'b0, wa} < DEPTH_W);

  // Clear and write never collide: writes are blocked for the whole sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (clr_en) begin
        mem_reg[clr_idx] <= '0;
      end
      if (we_ok) begin
        mem_reg[wa] <= din;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic          re_sel;
    logic [AW-1:0] ra_sel;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] dr_reg;

    assign re_sel = (gi == 0) ? re1 : re2;
    assign ra_sel = (gi == 0) ? ra1 : ra2;

    always_comb begin
      rd_val = '0;
      if ((ra_sel != '0) && ({1'b0, ra_sel} < DEPTH_W)) begin
        rd_val = mem_reg[ra_sel];
      end
`ifdef REG_BANK_P_BYPASS_EN
      if (we_ok && (ra_sel == wa)) begin
        rd_val = din;
      end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dr_reg <= '0;
      end else if (re_sel) begin
        dr_reg <= rd_val;
      end
    end
  end

  assign dr1 = g_rd[0].dr_reg;
  assign dr2 = g_rd[1].dr_reg;

endmodule

// File: tb/tb_reg_bank_p.sv
// Directed bench for reg_bank_p (default DW=32, DEPTH=32).
// Build with +define+REG_BANK_P_BYPASS_EN to exercise the forwarding variant.
module tb_reg_bank_p;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] din;
  logic          re1;
  logic [AW-1:0] ra1;
  logic [DW-1:0] dr1;
  logic          re2;
  logic [AW-1:0] ra2;
  logic [DW-1:0] dr2;
  logic          clr_req;
  logic          busy;

  int tests = 0;
  int fails = 0;

  reg_bank_p #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wa      (wa),
    .din     (din),
    .re1     (re1),
    .ra1     (ra1),
    .dr1     (dr1),
    .re2     (re2),
    .ra2     (ra2),
    .dr2     (dr2),
    .clr_req (clr_req),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp)
      $display("[TB] %-14s observed=%0d expected=%0d ok", tag, obs, exp);
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int busy_cnt;
    logic [DW-1:0] bypass_exp;

    rst = 1'b1; we = 1'b0; wa = '0; din = '0;
    re1 = 1'b0; ra1 = '0; re2 = 1'b0; ra2 = '0; clr_req = 1'b0;

    // Reset acts before any clock edge.
    #2;
    check("rst_dr1", dr1, 0);
    check("rst_dr2", dr2, 0);
    check("rst_busy", {31'd0, busy}, 0);
    step(); step();
    rst = 1'b0;

    // Read of never-written entry after reset.
    re1 = 1'b1; ra1 = 5;
    step();
    check("read_ra5", dr1, 0);
    check("idle_busy", {31'd0, busy}, 0);
    re1 = 1'b0;

    // Write then dual-port read of the same address.
    we = 1'b1; wa = 3; din = 69;
    step();
    we = 1'b0;
    re1 = 1'b1; ra1 = 3; re2 = 1'b1; ra2 = 3;
    step();
    check("dual_rd_p1", dr1, 69);
    check("dual_rd_p2", dr2, 69);

    // With enables low the outputs hold.
    re1 = 1'b0; re2 = 1'b0; ra1 = 5; ra2 = 5;
    step();
    check("hold_p1", dr1, 69);
    check("hold_p2", dr2, 69);

    // Entry 0 ignores writes.
    we = 1'b1; wa = 0; din = 49;
    step();
    we = 1'b0;
    re1 = 1'b1; ra1 = 0;
    step();
    check("entry0", dr1, 0);

    // Same-edge write and read of address 7.
`ifdef REG_BANK_P_BYPASS_EN
    bypass_exp = 7;
`else
    bypass_exp = 0;
`endif
    we = 1'b1; wa = 7; din = 7; re1 = 1'b1; ra1 = 7;
    step();
    check("same_edge", dr1, bypass_exp);
    we = 1'b0;
    step();
    check("after_write", dr1, 7);

    // Independent addresses on the two ports.
    re1 = 1'b1; ra1 = 3; re2 = 1'b1; ra2 = 7;
    step();
    check("indep_p1", dr1, 69);
    check("indep_p2", dr2, 7);

    // Fill entries 1..31 with 100+i.
    for (int i = 1; i < DEPTH; i++) begin
      we = 1'b1; wa = AW'(i); din = DW'(100 + i);
      step();
    end
    we = 1'b0;
    ra1 = 31; ra2 = 1;
    step();
    check("fill_31", dr1, 131);
    check("fill_1", dr2, 101);
    re1 = 1'b0; re2 = 1'b0;

    // Write and clear on the same edge: write commits, then sweep wipes it.
    we = 1'b1; wa = 5; din = 999; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("clr_busy_on", {31'd0, busy}, 1);
    busy_cnt = 1;
    // Keep hammering a write to an early entry for the whole sweep.
    we = 1'b1; wa = 9; din = 1; re1 = 1'b1; ra1 = 5;
    step();
    if (busy) busy_cnt++;
    check("wr_then_clr", dr1, 999);
    re1 = 1'b0;
    for (int k = 0; k < 100 && busy; k++) begin
      clr_req = (busy_cnt == 10);
      step();
      if (busy) busy_cnt++;
    end
    we = 1'b0; clr_req = 1'b0;
    check("busy_cycles", DW'(busy_cnt), 32);
    check("clr_done", {31'd0, busy}, 0);

    // Entire bank reads zero after the sweep.
    re1 = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      ra1 = AW'(i);
      step();
      check($sformatf("clr_e%0d", i), dr1, 0);
    end
    check("no_restart", {31'd0, busy}, 0);

    // Reset in the middle of a sweep.
    we = 1'b1; wa = 20; din = 220;
    step();
    we = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    ra1 = 20;
    for (int k = 0; k < 10; k++) step();
    check("pre_rst_dr1", dr1, 220);
    check("pre_rst_busy", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_dr1", dr1, 0);
    step();
    rst = 1'b0; re1 = 1'b0;

    // First edge after reset falls accepts a write.
    we = 1'b1; wa = 2; din = 125;
    step();
    we = 1'b0;
    check("no_resume", {31'd0, busy}, 0);
    re1 = 1'b1; ra1 = 2; re2 = 1'b1; ra2 = 20;
    step();
    check("post_rst_wr", dr1, 125);
    check("rst_zeroed", dr2, 0);
    step(); step();
    check("still_idle", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_bank_p.md
REG_BANK_P -- requirements
Module: reg_bank_p

Interface
REQ-001 Parameter DW, default 32, data width in bits (≥1).
REQ-002 Parameter DEPTH, default 32, number of entries (2..256); AW = $clog2(DEPTH) derived, not overridable.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 we  in  1; wa  in  AW; din  in  DW -- write request, address, data.
REQ-006 re1  in  1; ra1  in  AW; dr1  out  DW -- read port 1 enable, address, registered data.
REQ-007 re2  in  1; ra2  in  AW; dr2  out  DW -- read port 2 enable, address, registered data.
REQ-008 clr_req  in  1  request to zero the whole bank; busy  out  1  high while clearing.

Function
REQ-009 Storage: DEPTH x DW entries; entry 0 SHALL read as zero and ignore writes.
REQ-010 Write: at rising clk with we=1, busy=0, wa≠0, wa<DEPTH: mem[wa] <= din; otherwise no entry changes.
REQ-011 Read latency 1 cycle: re1=1 at edge -> dr1 <= mem[ra1]; re1=0 -> dr1 holds; port 2 identical and independent.
REQ-012 Read with ra≥DEPTH or ra=0 SHALL return 0.
REQ-013 Both read ports SHALL serve the same address in the same cycle with identical results.
REQ-014 Clear FSM states IDLE, CLEAR; IDLE->CLEAR on clr_req=1; CLEAR zeroes entry idx (counter 0..DEPTH-1) per cycle; idx=DEPTH-1 -> IDLE.
REQ-015 busy=1 exactly in CLEAR (registered, asserted the cycle after clr_req sampled); clear takes DEPTH cycles.
REQ-016 During CLEAR: we ignored, clr_req ignored, reads allowed and return current contents (cleared entries read 0).
REQ-017 Simultaneous we and clr_req in IDLE: write SHALL commit, clear starts next cycle and later zeroes it.

Reset
REQ-018 rst=1: all entries 0, dr1=dr2=0, busy=0, state IDLE, idx=0, taking effect immediately without clk.
REQ-019 rst during CLEAR SHALL abort the sweep; no pending clear resumes after deassertion.
REQ-020 First write accepted on the first rising clk after rst falls.

Configuration
REQ-021 Macro REG_BANK_P_BYPASS_EN defined: if we is accepted (REQ-010) and re1=1 with ra1=wa at the same edge, dr1 <= din; same for port 2.
REQ-022 Macro undefined: same-edge read of a written address SHALL return the pre-write value; new value visible one cycle later.

Structure
REQ-023 Package reg_bank_p_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and default DW/DEPTH constants.
REQ-024 Clear sequencer (FSM, idx counter, busy) SHALL be sub-module reg_bank_p_clr_seq; storage and read ports stay in reg_bank_p.

Verification
REQ-025 Reset then re1=1, ra1=5 -> dr1=0 one cycle later; busy=0.
REQ-026 we=1, wa=3, din=69; next cycle re1=1, ra1=3, re2=1, ra2=3 -> dr1=dr2=69 after one cycle.
REQ-027 we=1, wa=0, din=49; read ra1=0 -> dr1=0.
REQ-028 Same edge we=1, wa=7, din=7 with re1=1, ra1=7, prior value 0 -> dr1=7 with REG_BANK_P_BYPASS_EN, 0 without.
REQ-029 Load entries 1..31 with 100+i, pulse clr_req -> busy high 32 cycles, we during busy ignored, all reads 0 after.
REQ-030 Assert rst at cycle 10 of CLEAR -> busy=0 immediately, bank zero, write wa=2, din=125 then accepted, read returns 125.
